// File: rtl/fb_mem_arbiter.sv
// Framebuffer RAM arbiter: video scan-out has absolute priority, and the two
// generic requester ports (A, B) share the remaining cycles round-robin.
// Grants are combinational and made per cycle. Read responses come back one
// cycle later, steered by registered tags.
module fb_mem_arbiter #(
    parameter int H_VISIBLE = 640,
    parameter int V_VISIBLE = 480,
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = $clog2(H_VISIBLE * V_VISIBLE)
) (
    input  logic                         clk,
    input  logic                         rst,
    // video timer, next-cycle position
    input  logic                         visible_next,
    input  logic [$clog2(H_VISIBLE)-1:0] position_x_next,
    input  logic [$clog2(V_VISIBLE)-1:0] position_y_next,
    // scan-out pixel stream
    output logic [DATA_W-1:0]            pixel,
    output logic                         pixel_valid,
    // requester port A
    input  logic                         a_valid,
    output logic                         a_ready,
    input  logic                         a_we,
    input  logic [ADDR_W-1:0]            a_addr,
    input  logic [DATA_W-1:0]            a_wdata,
    output logic                         a_rvalid,
    output logic [DATA_W-1:0]            a_rdata,
    // requester port B
    input  logic                         b_valid,
    output logic                         b_ready,
    input  logic                         b_we,
    input  logic [ADDR_W-1:0]            b_addr,
    input  logic [DATA_W-1:0]            b_wdata,
    output logic                         b_rvalid,
    output logic [DATA_W-1:0]            b_rdata,
    // single-port synchronous-read RAM
    output logic                         mem_en,
    output logic                         mem_we,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [DATA_W-1:0]            mem_wdata,
    input  logic [DATA_W-1:0]            mem_rdata
);

    typedef enum logic [1:0] {
        GNT_IDLE,
        GNT_SCAN,
        GNT_A,
        GNT_B
    } grant_e;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    grant_e             grant;
    port_e              last_grant_q, last_grant_d;
    logic               scan_q, a_rd_q, b_rd_q;
    logic [ADDR_W-1:0]  scan_addr;

    // Row-major framebuffer address; the product is formed at ADDR_W width.
    assign scan_addr = ADDR_W'(position_y_next) * ADDR_W'(H_VISIBLE)
                     + ADDR_W'(position_x_next);

    // Grant decision: nothing during reset, then scan, then round-robin A/B.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and a latch is never inferred.
        grant = GNT_IDLE;
        if (!rst) begin
            grant = GNT_IDLE;
        end else if (visible_next) begin
            grant = GNT_SCAN;
        end else if (a_valid && b_valid) begin
            grant = (last_grant_q == PORT_A) ? GNT_B : GNT_A;
        end else if (a_valid) begin
            grant = GNT_A;
        end else if (b_valid) begin
            grant = GNT_B;
        end
    end

    // RAM command mux and handshake readies driven from the grant.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        a_ready   = 1'b0;
        b_ready   = 1'b0;
        unique case (grant)
            GNT_SCAN: begin
                mem_en   = 1'b1;
                mem_addr = scan_addr;
            end
            GNT_A: begin
                a_ready   = 1'b1;
                mem_en    = 1'b1;
                mem_we    = a_we;
                mem_addr  = a_addr;
                mem_wdata = a_wdata;
            end
            GNT_B: begin
                b_ready   = 1'b1;
                mem_en    = 1'b1;
                mem_we    = b_we;
                mem_addr  = b_addr;
                mem_wdata = b_wdata;
            end
            default: begin
                mem_en = 1'b0;
            end
        endcase
    end

    // Round-robin pointer only moves on a requester grant.
    always_comb begin
        last_grant_d = last_grant_q;
        if (grant == GNT_A) begin
            last_grant_d = PORT_A;
        end else if (grant == GNT_B) begin
            last_grant_d = PORT_B;
        end
    end

    // Response tags remember which source issued last cycle's read.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples values from before the clock edge.
        if (!rst) begin
            last_grant_q <= PORT_A;
            scan_q       <= 1'b0;
            a_rd_q       <= 1'b0;
            b_rd_q       <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            scan_q       <= (grant == GNT_SCAN);
            a_rd_q       <= (grant == GNT_A) && !a_we;
            b_rd_q       <= (grant == GNT_B) && !b_we;
        end
    end

    // Steer RAM read data to whichever source owns the response; others read 0.
    assign pixel_valid = scan_q;
    assign pixel       = scan_q ? mem_rdata : '0;
    assign a_rvalid    = a_rd_q;
    assign a_rdata     = a_rd_q ? mem_rdata : '0;
    assign b_rvalid    = b_rd_q;
    assign b_rdata     = b_rd_q ? mem_rdata : '0;

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Self-checking bench for fb_mem_arbiter: directed scenarios with hand-computed
// expectations, then a partial-frame run with random requester traffic and a
// response scoreboard. RAM words are initialised to (addr*7+3) mod 256.
module tb_fb_mem_arbiter;

    localparam int NWORDS = 640 * 480;

    logic        clk;
    logic        rst;
    logic        visible_next;
    logic [9:0]  position_x_next;
    logic [8:0]  position_y_next;
    logic [7:0]  pixel;
    logic        pixel_valid;
    logic        a_valid, a_ready, a_we, a_rvalid;
    logic [18:0] a_addr;
    logic [7:0]  a_wdata, a_rdata;
    logic        b_valid, b_ready, b_we, b_rvalid;
    logic [18:0] b_addr;
    logic [7:0]  b_wdata, b_rdata;
    logic        mem_en, mem_we;
    logic [18:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;

    logic [7:0]  ram [0:NWORDS-1];

    int n_tests = 0;
    int n_fail  = 0;

    fb_mem_arbiter #(
        .H_VISIBLE(640),
        .V_VISIBLE(480),
        .DATA_W   (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .visible_next   (visible_next),
        .position_x_next(position_x_next),
        .position_y_next(position_y_next),
        .pixel          (pixel),
        .pixel_valid    (pixel_valid),
        .a_valid        (a_valid),
        .a_ready        (a_ready),
        .a_we           (a_we),
        .a_addr         (a_addr),
        .a_wdata        (a_wdata),
        .a_rvalid       (a_rvalid),
        .a_rdata        (a_rdata),
        .b_valid        (b_valid),
        .b_ready        (b_ready),
        .b_we           (b_we),
        .b_addr         (b_addr),
        .b_wdata        (b_wdata),
        .b_rvalid       (b_rvalid),
        .b_rdata        (b_rdata),
        .mem_en         (mem_en),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single-port synchronous-read RAM model.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        visible_next    = 1'b0;
        position_x_next = '0;
        position_y_next = '0;
        a_valid = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_valid = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    endtask

    task automatic reset_pulse();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    // Partial-frame scoreboard state.
    int          pix_cnt, overlap_err, resp_err, a_grants, b_grants;
    int          wait_a, wait_b, max_wait;
    logic        pend_s, pend_a, pend_b, a_fire, b_fire;
    logic [7:0]  exp_s, exp_a, exp_b;
    int          y;

    initial begin
        for (int i = 0; i < NWORDS; i++) ram[i] = 8'(i * 7 + 3);
        mem_rdata = '0;
        idle_inputs();
        rst = 1'b0;

        // ---- reset state, with hostile inputs held ----
        visible_next = 1'b1;
        a_valid = 1'b1;
        b_valid = 1'b1;
        #2;
        check("rst_mem_en",      mem_en,      0);
        check("rst_a_ready",     a_ready,     0);
        check("rst_b_ready",     b_ready,     0);
        check("rst_pixel_valid", pixel_valid, 0);
        check("rst_pixel",       pixel,       0);
        check("rst_a_rvalid",    a_rvalid,    0);
        check("rst_b_rvalid",    b_rvalid,    0);
        check("rst_a_rdata",     a_rdata,     0);
        step();
        check("rst_mem_en_after_edge", mem_en, 0);
        check("rst_pv_after_edge",     pixel_valid, 0);
        idle_inputs();
        rst = 1'b1;
        step();

        // ---- scan read at (3,2): address 1283, RAM[1283] = 0x18 ----
        visible_next = 1'b1;
        position_x_next = 10'd3;
        position_y_next = 9'd2;
        #1;
        check("scan_mem_addr", mem_addr, 1283);
        check("scan_mem_en",   mem_en,   1);
        check("scan_mem_we",   mem_we,   0);
        step();
        visible_next = 1'b0;
        #1;
        check("scan_pixel_valid", pixel_valid, 1);
        check("scan_pixel",       pixel,       8'h18);
        check("idle_mem_en",      mem_en,      0);
        step();
        check("scan_pv_drop", pixel_valid, 0);

        // ---- contention during visible: A waits 5 cycles, then gets blanking ----
        a_valid = 1'b1; a_we = 1'b0; a_addr = 19'd5;
        for (int i = 0; i < 5; i++) begin
            visible_next = 1'b1;
            position_x_next = 10'(i);
            position_y_next = 9'd0;
            #1;
            check($sformatf("contend_a_ready_%0d", i), a_ready, 0);
            check($sformatf("contend_scan_en_%0d", i), mem_addr, i);
            step();
        end
        visible_next = 1'b0;
        #1;
        check("contend_blank_a_ready", a_ready, 1);
        check("contend_blank_b_ready", b_ready, 0);
        step();
        a_valid = 1'b0;
        #1;
        check("contend_a_rvalid",  a_rvalid,    1);
        check("contend_a_rdata",   a_rdata,     8'h26);
        check("contend_pv_off",    pixel_valid, 0);

        // ---- round-robin after reset: B, A, B, A ----
        step();
        reset_pulse();
        a_valid = 1'b1; a_we = 1'b0; a_addr = 19'd10;
        b_valid = 1'b1; b_we = 1'b0; b_addr = 19'd20;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("rr_a_ready_%0d", i), a_ready, (i % 2 == 1));
            check($sformatf("rr_b_ready_%0d", i), b_ready, (i % 2 == 0));
            step();
            if (i == 0) begin
                check("rr_b_rvalid", b_rvalid, 1);
                check("rr_b_rdata",  b_rdata,  8'h8F);
                check("rr_a_rvalid_quiet", a_rvalid, 0);
            end
        end
        check("rr_last_a_rvalid", a_rvalid, 1);
        check("rr_last_a_rdata",  a_rdata,  8'h49);
        idle_inputs();
        step();

        // ---- write then read: A writes 0x5A @100, B reads @100 next cycle ----
        a_valid = 1'b1; a_we = 1'b1; a_addr = 19'd100; a_wdata = 8'h5A;
        #1;
        check("wr_a_ready", a_ready, 1);
        check("wr_mem_we",  mem_we,  1);
        step();
        a_valid = 1'b0; a_we = 1'b0;
        b_valid = 1'b1; b_we = 1'b0; b_addr = 19'd100;
        #1;
        check("rd_b_ready",       b_ready,  1);
        check("wr_no_a_rvalid_0", a_rvalid, 0);
        step();
        b_valid = 1'b0;
        #1;
        check("rd_b_rvalid",      b_rvalid, 1);
        check("rd_b_rdata",       b_rdata,  8'h5A);
        check("wr_no_a_rvalid_1", a_rvalid, 0);
        step();

        // ---- reset in the cycle after an A read grant ----
        a_valid = 1'b1; a_we = 1'b0; a_addr = 19'd7;
        #1;
        check("rstmid_a_ready", a_ready, 1);
        step();
        rst = 1'b0;
        a_valid = 1'b1;
        b_valid = 1'b1; b_we = 1'b0; b_addr = 19'd9;
        #1;
        check("rstmid_a_rvalid", a_rvalid, 0);
        check("rstmid_mem_en",   mem_en,   0);
        check("rstmid_a_ready0", a_ready,  0);
        step();
        check("rstmid_mem_en_hold", mem_en, 0);
        rst = 1'b1;
        #1;
        check("rstmid_first_b", b_ready, 1);
        check("rstmid_first_a", a_ready, 0);
        step();
        idle_inputs();
        #1;
        check("rstmid_b_rdata", b_rdata, 8'h42);
        step();

        // ---- partial frame (lines 0..19, 470..489) with random traffic ----
        pix_cnt = 0; overlap_err = 0; resp_err = 0; a_grants = 0; b_grants = 0;
        wait_a = 0; wait_b = 0; max_wait = 0;
        pend_s = 1'b0; pend_a = 1'b0; pend_b = 1'b0;
        a_fire = 1'b0; b_fire = 1'b0;
        exp_s = '0; exp_a = '0; exp_b = '0;
        for (int li = 0; li <= 40; li++) begin
            y = (li < 20) ? li : 450 + li;
            for (int x = 0; x < 800; x++) begin
                // responses for last cycle's grants
                if (pixel_valid) pix_cnt++;
                if (pixel_valid !== pend_s || pixel !== (pend_s ? exp_s : 8'h00)) resp_err++;
                if (a_rvalid !== pend_a || a_rdata !== (pend_a ? exp_a : 8'h00)) resp_err++;
                if (b_rvalid !== pend_b || b_rdata !== (pend_b ? exp_b : 8'h00)) resp_err++;
                if (li == 40) break;  // drain cycle only
                // requester stimulus obeying the hold-until-ready rule
                if (a_fire) a_valid = 1'b0;
                if (b_fire) b_valid = 1'b0;
                if (!a_valid && $urandom_range(0, 2) == 0) begin
                    a_valid = 1'b1; a_we = 1'($urandom_range(0, 1));
                    a_addr = 19'($urandom_range(0, NWORDS - 1)); a_wdata = 8'($urandom);
                end
                if (!b_valid && $urandom_range(0, 2) == 0) begin
                    b_valid = 1'b1; b_we = 1'($urandom_range(0, 1));
                    b_addr = 19'($urandom_range(0, NWORDS - 1)); b_wdata = 8'($urandom);
                end
                visible_next    = (x < 640) && (y < 480);
                position_x_next = 10'(x);
                position_y_next = 9'(y);
                #1;
                if ((int'(visible_next) + int'(a_ready) + int'(b_ready)) > 1) overlap_err++;
                if (mem_en !== (visible_next || a_ready || b_ready)) overlap_err++;
                if ((a_ready && !a_valid) || (b_ready && !b_valid)) overlap_err++;
                if (!visible_next && (a_valid || b_valid) && !(a_ready || b_ready)) overlap_err++;
                pend_s = visible_next;
                exp_s  = visible_next ? ram[y * 640 + x] : 8'h00;
                pend_a = a_ready && !a_we;
                exp_a  = ram[a_addr];
                pend_b = b_ready && !b_we;
                exp_b  = ram[b_addr];
                a_fire = a_valid && a_ready;
                b_fire = b_valid && b_ready;
                if (a_fire) a_grants++;
                if (b_fire) b_grants++;
                wait_a = (a_valid && !a_ready) ? wait_a + 1 : 0;
                wait_b = (b_valid && !b_ready) ? wait_b + 1 : 0;
                if (wait_a > max_wait) max_wait = wait_a;
                if (wait_b > max_wait) max_wait = wait_b;
                step();
            end
        end
        check("frame_pixel_count", pix_cnt,     30 * 640);
        check("frame_overlap",     overlap_err, 0);
        check("frame_responses",   resp_err,    0);
        check("frame_a_served",    a_grants > 0, 1);
        check("frame_b_served",    b_grants > 0, 1);
        check("frame_wait_bound",  max_wait <= 641, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
